lc3_mem_arbiter: RTL and testbench



---
 rtl/lc3_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// Arbiter sharing one single-ported memory between LC3 instruction fetch and data access.
// Data wins by default; a streak limit forces pending fetches through, and a watchdog aborts hung cycles.
module lc3_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 3,
    parameter int TIMEOUT         = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [15:0] instr_addr,
    output logic [15:0] instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_din,
    output logic [15:0] data_dout,
    output logic        complete_data,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] WD_LIMIT   = 8'(TIMEOUT);

    state_t     state;
    logic [3:0] streak;
    logic [7:0] watchdog;
    logic       streak_full;
    logic       grant_d;
    logic       grant_i;
    logic [3:0] streak_inc;

    // A pending fetch only overrides data once the data streak has hit its limit.
    assign streak_full = (streak == STREAK_MAX);
    assign grant_d     = data_req && !(instr_req && streak_full);
    assign grant_i     = instr_req && !grant_d;
    assign streak_inc  = streak_full ? streak : streak + 4'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            streak         <= '0;
            watchdog       <= '0;
            instr_dout     <= '0;
            complete_instr <= 1'b0;
            data_dout      <= '0;
            complete_data  <= 1'b0;
            mem_addr       <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_wdata      <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_BUSY;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_din;
                        mem_rd    <= !data_we;
                        mem_wr    <= data_we;
                        watchdog  <= 8'd1;
                        streak    <= instr_req ? streak_inc : 4'd0;
                    end else if (grant_i) begin
                        state     <= I_BUSY;
                        mem_addr  <= instr_addr;
                        mem_wdata <= '0;
                        mem_rd    <= 1'b1;
                        mem_wr    <= 1'b0;
                        watchdog  <= 8'd1;
                        streak    <= '0;
                    end
                end
                I_BUSY: begin
                    if (mem_ready) begin
                        state          <= DONE;
                        mem_rd         <= 1'b0;
                        instr_dout     <= mem_rdata;
                        complete_instr <= 1'b1;
                    end else if (watchdog == WD_LIMIT) begin
                        state          <= DONE;
                        mem_rd         <= 1'b0;
                        instr_dout     <= '0;
                        complete_instr <= 1'b1;
                        timeout_err    <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                D_BUSY: begin
                    // Aborted accesses still complete so the pipeline never stalls forever.
                    if (mem_ready) begin
                        state         <= DONE;
                        mem_rd        <= 1'b0;
                        mem_wr        <= 1'b0;
                        complete_data <= 1'b1;
                        if (mem_rd) begin
                            data_dout <= mem_rdata;
                        end
                    end else if (watchdog == WD_LIMIT) begin
                        state         <= DONE;
                        mem_rd        <= 1'b0;
                        mem_wr        <= 1'b0;
                        data_dout     <= '0;
                        complete_data <= 1'b1;
                        timeout_err   <= 1'b1;
                    end else begin
                        watchdog <= watchdog + 8'd1;
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    complete_instr <= 1'b0;
                    complete_data  <= 1'b0;
                    watchdog       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed self-checking bench for lc3_mem_arbiter (MAX_DATA_STREAK=3, TIMEOUT=8).
module tb_lc3_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic [15:0] instr_dout;
    logic        complete_instr;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout;
    logic        complete_data;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        timeout_err;

    int num_checks;
    int num_errors;

    lc3_mem_arbiter #(.MAX_DATA_STREAK(3), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_dout(instr_dout),
        .complete_instr(complete_instr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_din(data_din),
        .data_dout(data_dout), .complete_data(complete_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Mutual exclusion of completes and strobes is checked on every falling edge out of reset.
    always @(negedge clock) begin
        if (reset) begin
            checkOutput("excl_complete", 16'(complete_instr & complete_data), 16'h0);
            checkOutput("excl_strobe", 16'(mem_rd & mem_wr), 16'h0);
        end
    end

    logic        exp_d [5];
    logic [15:0] saved_dout;

    initial begin
        num_checks = 0;
        num_errors = 0;
        reset = 1'b0;
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_we = 0; data_addr = '0; data_din = '0;
        mem_rdata = '0; mem_ready = 0;
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        #1;
        checkOutput("rst_mem_rd", 16'(mem_rd), 16'h0);
        checkOutput("rst_mem_wr", 16'(mem_wr), 16'h0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0);
        checkOutput("rst_dout", instr_dout | data_dout | mem_wdata, 16'h0);
        checkOutput("rst_complete", 16'({complete_instr, complete_data}), 16'h0);
        checkOutput("rst_err", 16'(timeout_err), 16'h0);
        tick();
        reset = 1'b1;

        // Test 1: zero-wait fetch, then re-grant spacing
        instr_req = 1; instr_addr = 16'h3000; mem_ready = 1; mem_rdata = 16'h1234;
        tick();
        checkOutput("t1_rd", 16'(mem_rd), 16'h1);
        checkOutput("t1_addr", mem_addr, 16'h3000);
        checkOutput("t1_cmpl_early", 16'(complete_instr), 16'h0);
        instr_addr = 16'h3001;
        tick();
        checkOutput("t1_rd_drop", 16'(mem_rd), 16'h0);
        checkOutput("t1_cmpl", 16'(complete_instr), 16'h1);
        checkOutput("t1_dout", instr_dout, 16'h1234);
        tick();
        checkOutput("t1_cmpl_once", 16'(complete_instr), 16'h0);
        checkOutput("t1_no_grant_idle", 16'(mem_rd), 16'h0);
        tick();
        checkOutput("t1_regrant", 16'(mem_rd), 16'h1);
        checkOutput("t1_regrant_addr", mem_addr, 16'h3001);
        tick();
        checkOutput("t1_cmpl2", 16'(complete_instr), 16'h1);
        instr_req = 0;
        tick();

        // Test 2: streak limit, expected grant order D,D,D,I,D
        instr_req = 1; instr_addr = 16'h3100;
        data_req = 1; data_we = 0; data_addr = 16'h5000;
        mem_ready = 1;
        for (int k = 0; k < 5; k++) begin
            mem_rdata = 16'hA000 + 16'(k);
            tick();
            checkOutput($sformatf("t2_rd_%0d", k), 16'(mem_rd), 16'h1);
            checkOutput($sformatf("t2_addr_%0d", k), mem_addr, exp_d[k] ? 16'h5000 : 16'h3100);
            tick();
            checkOutput($sformatf("t2_cd_%0d", k), 16'(complete_data), 16'(exp_d[k]));
            checkOutput($sformatf("t2_ci_%0d", k), 16'(complete_instr), 16'(!exp_d[k]));
            if (exp_d[k]) checkOutput($sformatf("t2_ddout_%0d", k), data_dout, 16'hA000 + 16'(k));
            else          checkOutput($sformatf("t2_idout_%0d", k), instr_dout, 16'hA000 + 16'(k));
            if (k == 4) begin
                instr_req = 0; data_req = 0;
            end
            tick();
        end
        mem_ready = 0;

        // Test 3: delayed write holds address and data stable
        saved_dout = 16'hA004;
        data_req = 1; data_we = 1; data_addr = 16'h4000; data_din = 16'hBEEF;
        tick();
        checkOutput("t3_wr", 16'(mem_wr), 16'h1);
        checkOutput("t3_rd", 16'(mem_rd), 16'h0);
        data_addr = 16'h1111; data_din = 16'h2222; data_we = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput($sformatf("t3_wr_hold_%0d", i), 16'(mem_wr), 16'h1);
            checkOutput($sformatf("t3_addr_%0d", i), mem_addr, 16'h4000);
            checkOutput($sformatf("t3_wdata_%0d", i), mem_wdata, 16'hBEEF);
        end
        mem_ready = 1; mem_rdata = 16'hDEAD;
        tick();
        checkOutput("t3_wr_drop", 16'(mem_wr), 16'h0);
        checkOutput("t3_cmpl", 16'(complete_data), 16'h1);
        checkOutput("t3_dout_kept", data_dout, saved_dout);
        checkOutput("t3_err", 16'(timeout_err), 16'h0);
        data_req = 0; mem_ready = 0;
        tick();

        // Test 4: fetch timeout after 8 busy cycles
        instr_req = 1; instr_addr = 16'h3200; mem_rdata = 16'hFFFF;
        tick();
        checkOutput("t4_rd", 16'(mem_rd), 16'h1);
        for (int i = 1; i <= 7; i++) tick();
        checkOutput("t4_rd_cycle8", 16'(mem_rd), 16'h1);
        checkOutput("t4_err_before", 16'(timeout_err), 16'h0);
        tick();
        checkOutput("t4_rd_abort", 16'(mem_rd), 16'h0);
        checkOutput("t4_cmpl", 16'(complete_instr), 16'h1);
        checkOutput("t4_dout_zero", instr_dout, 16'h0000);
        checkOutput("t4_err", 16'(timeout_err), 16'h1);
        instr_req = 0;
        tick();
        data_req = 1; data_we = 0; data_addr = 16'h4400; mem_ready = 1; mem_rdata = 16'h0F0F;
        tick();
        tick();
        checkOutput("t4_next_cmpl", 16'(complete_data), 16'h1);
        checkOutput("t4_next_dout", data_dout, 16'h0F0F);
        checkOutput("t4_err_sticky", 16'(timeout_err), 16'h1);
        data_req = 0; mem_ready = 0;
        tick();

        // Test 5: reset during a data access
        data_req = 1; data_we = 0; data_addr = 16'h4100;
        tick();
        checkOutput("t5_rd", 16'(mem_rd), 16'h1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5_rd_async", 16'(mem_rd), 16'h0);
        checkOutput("t5_err_cleared", 16'(timeout_err), 16'h0);
        mem_ready = 1; mem_rdata = 16'h5A5A;
        tick();
        checkOutput("t5_no_cmpl", 16'(complete_data), 16'h0);
        checkOutput("t5_rd_held_low", 16'(mem_rd), 16'h0);
        reset = 1'b1;
        tick();
        checkOutput("t5_regrant", 16'(mem_rd), 16'h1);
        checkOutput("t5_regrant_addr", mem_addr, 16'h4100);
        tick();
        checkOutput("t5_cmpl", 16'(complete_data), 16'h1);
        checkOutput("t5_dout", data_dout, 16'h5A5A);
        data_req = 0; mem_ready = 0;
        tick();

        // Test 6: mem_ready coinciding with the timeout wins
        instr_req = 1; instr_addr = 16'h3300; mem_rdata = 16'h7777;
        tick();
        for (int i = 1; i <= 7; i++) tick();
        checkOutput("t6_rd_cycle8", 16'(mem_rd), 16'h1);
        mem_ready = 1;
        tick();
        checkOutput("t6_cmpl", 16'(complete_instr), 16'h1);
        checkOutput("t6_dout", instr_dout, 16'h7777);
        checkOutput("t6_no_err", 16'(timeout_err), 16'h0);
        instr_req = 0; mem_ready = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
